// File: rtl/cu_astat_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cu_astat_reg : ASTAT status / STKY sticky-flag register with condition eval
// Revision     : 1.0
// ---------------------------------------------------------------------------
module cu_astat_reg #(
    parameter int DATASIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps_alu_en,
    input  logic                ps_mul_en,
    input  logic                ps_shf_en,
    input  logic                alu_ps_az,
    input  logic                alu_ps_an,
    input  logic                alu_ps_av,
    input  logic                alu_ps_ac,
    input  logic                mul_ps_mn,
    input  logic                mul_ps_mv,
    input  logic                shf_ps_sz,
    input  logic                shf_ps_sv,
    input  logic                ps_astat_wen,
    input  logic                ps_stky_wen,
    input  logic [DATASIZE-1:0] xb_dt,
    input  logic [3:0]          ps_cond,
    output logic [DATASIZE-1:0] astat_xb_dt,
    output logic [DATASIZE-1:0] stky_xb_dt,
    output logic                astat_ps_cond
);

    logic       alu_pend_q, mul_pend_q, shf_pend_q;
    logic [7:0] astat_q, astat_d;
    logic [2:0] stky_q, stky_d;
    logic       unused_xb;

    assign unused_xb = ^xb_dt[DATASIZE-1:8];

    // Unit captures are applied after the crossbar write so they win per field.
    always_comb begin
        astat_d = ps_astat_wen ? xb_dt[7:0] : astat_q;
        stky_d  = ps_stky_wen  ? xb_dt[2:0] : stky_q;
        if (alu_pend_q) begin
            astat_d[3:0] = {alu_ps_ac, alu_ps_av, alu_ps_an, alu_ps_az};
            stky_d[0]    = stky_d[0] | alu_ps_av;
        end
        if (mul_pend_q) begin
            astat_d[5:4] = {mul_ps_mv, mul_ps_mn};
            stky_d[1]    = stky_d[1] | mul_ps_mv;
        end
        if (shf_pend_q) begin
            astat_d[7:6] = {shf_ps_sv, shf_ps_sz};
            stky_d[2]    = stky_d[2] | shf_ps_sv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_pend_q <= 1'b0;
            mul_pend_q <= 1'b0;
            shf_pend_q <= 1'b0;
            astat_q    <= 8'h00;
            stky_q     <= 3'b000;
        end else begin
            alu_pend_q <= ps_alu_en;
            mul_pend_q <= ps_mul_en;
            shf_pend_q <= ps_shf_en;
            astat_q    <= astat_d;
            stky_q     <= stky_d;
        end
    end

    assign astat_xb_dt = {{(DATASIZE-8){1'b0}}, astat_q};
    assign stky_xb_dt  = {{(DATASIZE-3){1'b0}}, stky_q};

    always_comb begin
        astat_ps_cond = 1'b1;
        case (ps_cond)
            4'd0:    astat_ps_cond =  astat_q[0];
            4'd1:    astat_ps_cond = ~astat_q[0];
            4'd2:    astat_ps_cond =  astat_q[1];
            4'd3:    astat_ps_cond = ~astat_q[1];
            4'd4:    astat_ps_cond =  (astat_q[1] | astat_q[0]);
            4'd5:    astat_ps_cond = ~(astat_q[1] | astat_q[0]);
            4'd6:    astat_ps_cond =  astat_q[2];
            4'd7:    astat_ps_cond = ~astat_q[2];
            4'd8:    astat_ps_cond =  astat_q[3];
            4'd9:    astat_ps_cond = ~astat_q[3];
            4'd10:   astat_ps_cond =  astat_q[5];
            4'd11:   astat_ps_cond = ~astat_q[5];
            4'd12:   astat_ps_cond =  astat_q[7];
            4'd13:   astat_ps_cond = ~astat_q[7];
            4'd14:   astat_ps_cond =  astat_q[6];
            default: astat_ps_cond = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cu_astat_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cu_astat_reg : directed + randomized self-checking bench for cu_astat_reg
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_cu_astat_reg;

    localparam int DATASIZE = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ps_alu_en = 0, ps_mul_en = 0, ps_shf_en = 0;
    logic                alu_ps_az = 0, alu_ps_an = 0, alu_ps_av = 0, alu_ps_ac = 0;
    logic                mul_ps_mn = 0, mul_ps_mv = 0, shf_ps_sz = 0, shf_ps_sv = 0;
    logic                ps_astat_wen = 0, ps_stky_wen = 0;
    logic [DATASIZE-1:0] xb_dt = '0;
    logic [3:0]          ps_cond = '0;
    logic [DATASIZE-1:0] astat_xb_dt, stky_xb_dt;
    logic                astat_ps_cond;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    cu_astat_reg #(.DATASIZE(DATASIZE)) dut (
        .clk(clk), .rst(rst),
        .ps_alu_en(ps_alu_en), .ps_mul_en(ps_mul_en), .ps_shf_en(ps_shf_en),
        .alu_ps_az(alu_ps_az), .alu_ps_an(alu_ps_an), .alu_ps_av(alu_ps_av), .alu_ps_ac(alu_ps_ac),
        .mul_ps_mn(mul_ps_mn), .mul_ps_mv(mul_ps_mv),
        .shf_ps_sz(shf_ps_sz), .shf_ps_sv(shf_ps_sv),
        .ps_astat_wen(ps_astat_wen), .ps_stky_wen(ps_stky_wen),
        .xb_dt(xb_dt), .ps_cond(ps_cond),
        .astat_xb_dt(astat_xb_dt), .stky_xb_dt(stky_xb_dt), .astat_ps_cond(astat_ps_cond)
    );

    always #5 clk = ~clk;

    // Reference model: named flag sets per unit, a pending flag per unit.
    logic [7:0] m_astat = '0;
    logic [2:0] m_stky  = '0;
    bit         m_pend [3];
    logic [7:0] nxt;
    logic [2:0] nstk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_astat = '0;
            m_stky  = '0;
            for (int u = 0; u < 3; u++) m_pend[u] = 1'b0;
        end else begin
            nxt  = ps_astat_wen ? xb_dt[7:0] : m_astat;
            nstk = ps_stky_wen  ? xb_dt[2:0] : m_stky;
            if (m_pend[0]) begin
                nxt[0] = alu_ps_az; nxt[1] = alu_ps_an; nxt[2] = alu_ps_av; nxt[3] = alu_ps_ac;
                if (alu_ps_av) nstk[0] = 1'b1;
            end
            if (m_pend[1]) begin
                nxt[4] = mul_ps_mn; nxt[5] = mul_ps_mv;
                if (mul_ps_mv) nstk[1] = 1'b1;
            end
            if (m_pend[2]) begin
                nxt[6] = shf_ps_sz; nxt[7] = shf_ps_sv;
                if (shf_ps_sv) nstk[2] = 1'b1;
            end
            m_astat = nxt;
            m_stky  = nstk;
            m_pend[0] = ps_alu_en;
            m_pend[1] = ps_mul_en;
            m_pend[2] = ps_shf_en;
        end
    end

    // Codes come in true/inverted pairs; 14/15 are SZ and TRUE.
    function automatic bit exp_cond(input logic [3:0] c, input logic [7:0] a);
        bit base;
        logic [2:0] pair;
        pair = c[3:1];
        case (pair)
            3'd0: base = a[0];
            3'd1: base = a[1];
            3'd2: base = a[1] | a[0];
            3'd3: base = a[2];
            3'd4: base = a[3];
            3'd5: base = a[5];
            3'd6: base = a[7];
            default: base = a[6];
        endcase
        if (c == 4'd15) return 1'b1;
        if (c == 4'd14) return a[6];
        return base ^ c[0];
    endfunction

    task automatic check(input string name, input logic [DATASIZE-1:0] act,
                         input logic [DATASIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_astat", astat_xb_dt, {8'h00, m_astat});
            check("model_stky",  stky_xb_dt,  {13'h0, m_stky});
            check("model_cond",  {15'h0, astat_ps_cond}, {15'h0, exp_cond(ps_cond, m_astat)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        {ps_alu_en, ps_mul_en, ps_shf_en} = '0;
        {alu_ps_az, alu_ps_an, alu_ps_av, alu_ps_ac} = '0;
        {mul_ps_mn, mul_ps_mv, shf_ps_sz, shf_ps_sv} = '0;
        {ps_astat_wen, ps_stky_wen} = '0;
        xb_dt = '0;
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk_on = 1'b1;
        tick();

        // Reset state: only odd codes are true.
        for (int c = 0; c < 16; c++) begin
            ps_cond = 4'(c);
            #1;
            check("reset_cond", {15'h0, astat_ps_cond}, {15'h0, (c % 2 == 1)});
        end
        check("reset_astat", astat_xb_dt, 16'h0000);
        check("reset_stky",  stky_xb_dt,  16'h0000);

        // Shifter capture; non-pending unit flags toggle without effect.
        ps_shf_en = 1'b1;
        tick();
        ps_shf_en = 1'b0;
        shf_ps_sz = 1'b0; shf_ps_sv = 1'b1;
        {alu_ps_az, alu_ps_an, alu_ps_av, alu_ps_ac, mul_ps_mn, mul_ps_mv} = 6'b111111;
        tick();
        clr_inputs();
        ps_cond = 4'd12;
        #1;
        check("shf_astat", astat_xb_dt, 16'h0080);
        check("shf_stky",  stky_xb_dt,  16'h0004);
        check("shf_cond12", {15'h0, astat_ps_cond}, 16'h0001);

        // Clear sticky, then capture from all three units at once.
        ps_stky_wen = 1'b1; xb_dt = 16'h0000;
        tick();
        clr_inputs();
        {ps_alu_en, ps_mul_en, ps_shf_en} = 3'b111;
        tick();
        clr_inputs();
        alu_ps_az = 1'b1; mul_ps_mn = 1'b1; shf_ps_sz = 1'b1;
        tick();
        clr_inputs();
        check("all3_astat", astat_xb_dt, 16'h0051);
        check("all3_stky",  stky_xb_dt,  16'h0000);

        // Crossbar write colliding with a shifter capture.
        ps_shf_en = 1'b1;
        tick();
        clr_inputs();
        ps_astat_wen = 1'b1; xb_dt = 16'hFFFF;
        tick();
        clr_inputs();
        check("wr_vs_cap_astat", astat_xb_dt, 16'h003F);

        // Sticky clear colliding with a multiplier overflow: set wins.
        ps_stky_wen = 1'b1; xb_dt = 16'h0007;
        tick();
        clr_inputs();
        check("stky_all_set", stky_xb_dt, 16'h0007);
        ps_mul_en = 1'b1;
        tick();
        clr_inputs();
        ps_stky_wen = 1'b1; mul_ps_mv = 1'b1;
        tick();
        clr_inputs();
        check("stky_set_wins", stky_xb_dt, 16'h0002);

        // Reset in flight drops the pending ALU capture.
        ps_alu_en = 1'b1;
        tick();
        clr_inputs();
        rst = 1'b1;
        {alu_ps_az, alu_ps_an, alu_ps_av, alu_ps_ac} = 4'hF;
        tick();
        rst = 1'b0;
        tick();
        clr_inputs();
        alu_ps_az = 1'b1; alu_ps_ac = 1'b1;
        check("rst_astat_n3", astat_xb_dt, 16'h0000);
        tick();
        check("rst_astat_n4", astat_xb_dt, 16'h0000);
        check("rst_stky",     stky_xb_dt,  16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ps_alu_en = 1'($urandom_range(0, 1));
            ps_mul_en = 1'($urandom_range(0, 1));
            ps_shf_en = 1'($urandom_range(0, 1));
            {alu_ps_az, alu_ps_an, alu_ps_av, alu_ps_ac} = 4'($urandom);
            {mul_ps_mn, mul_ps_mv, shf_ps_sz, shf_ps_sv} = 4'($urandom);
            ps_astat_wen = ($urandom_range(0, 7) == 0);
            ps_stky_wen  = ($urandom_range(0, 7) == 0);
            xb_dt   = 16'($urandom);
            ps_cond = 4'($urandom);
            if (i == 300) rst = 1'b1;
            if (i == 302) rst = 1'b0;
            tick();
        end
        clr_inputs();
        tick();
        @(negedge clk);
        #1;
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
